vm_multiplier: RTL and testbench

- Signed 32x32 -> 64-bit two's-complement integer multiplier for the multiplier-comparison datapath.
- Pipelined with a fixed latency of 2 cycles and a valid strobe.
- The datapath uses radix-4 Booth partial products, carry-save (Wallace/Dadda) reduction and a final carry-propagate adder.
- The behavioural `*` operator is not used in the datapath.

---
 rtl/vm_multiplier.sv | 173 +++++++++++++++++
 tb/tb_vm_multiplier.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vm_multiplier.sv
// Signed WIDTH x WIDTH -> 2*WIDTH multiplier: radix-4 Booth partial products,
// a 3:2 carry-save reduction tree and one carry-propagate add, two register stages.
module vm_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int PW    = 2 * WIDTH;
  localparam int NDIG  = WIDTH / 2;
  localparam int NROWS = NDIG + 1;

  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_t;

  function automatic int rows_after(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int rows_at_level(input int lvl);
    int n;
    n = NROWS;
    for (int i = 0; i < lvl; i++) begin
      n = rows_after(n);
    end
    return n;
  endfunction

  function automatic int level_count();
    int n;
    int l;
    n = NROWS;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = rows_after(n);
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int NLVL = level_count();

  function automatic booth_t booth_decode(input logic [2:0] trip);
    booth_t d;
    case (trip)
      3'b000, 3'b111: d = '{neg: 1'b0, two: 1'b0, one: 1'b0};
      3'b001, 3'b010: d = '{neg: 1'b0, two: 1'b0, one: 1'b1};
      3'b011:         d = '{neg: 1'b0, two: 1'b1, one: 1'b0};
      3'b100:         d = '{neg: 1'b1, two: 1'b1, one: 1'b0};
      3'b101, 3'b110: d = '{neg: 1'b1, two: 1'b0, one: 1'b1};
      default:        d = '{neg: 1'b0, two: 1'b0, one: 1'b0};
    endcase
    return d;
  endfunction

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             v1_r;
  logic             out_valid_r;
  logic [PW-1:0]    result_r;

  logic [WIDTH:0]   b_ext_s;
  logic [PW-1:0]    a_ext_s;
  booth_t           dig_s  [NDIG];
  logic [PW-1:0]    mag_s  [NDIG];
  logic [PW-1:0]    pp_s   [NROWS];
  logic [PW-1:0]    corr_s;
  logic [PW-1:0]    tree_s [0:NLVL][0:NROWS-1];
  logic [PW-1:0]    prod_s;

  // Stage-1 operand capture; operands hold while no new pair arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      v1_r <= 1'b0;
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
      end else begin
        a_r <= a_r;
        b_r <= b_r;
      end
    end
  end

  assign b_ext_s = {b_r, 1'b0};
  assign a_ext_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};

  // Booth digits select 0/A/2A, negative digits invert and park their +1 in a correction row
  always_comb begin
    corr_s = '0;
    for (int i = 0; i < NDIG; i++) begin
      dig_s[i] = booth_decode(b_ext_s[2*i +: 3]);
      if (dig_s[i].two) begin
        mag_s[i] = a_ext_s << 1;
      end else if (dig_s[i].one) begin
        mag_s[i] = a_ext_s;
      end else begin
        mag_s[i] = '0;
      end
      pp_s[i]     = (dig_s[i].neg ? ~mag_s[i] : mag_s[i]) << (2 * i);
      corr_s[2*i] = dig_s[i].neg;
    end
    pp_s[NDIG] = corr_s;
  end

  for (genvar r = 0; r < NROWS; r++) begin : g_lvl0
    assign tree_s[0][r] = pp_s[r];
  end

  // Each level compresses rows in groups of three; leftovers pass straight through
  for (genvar l = 1; l <= NLVL; l++) begin : g_lvl
    localparam int PCNT  = rows_at_level(l - 1);
    localparam int NCSA  = PCNT / 3;
    localparam int NPASS = PCNT - 3 * NCSA;
    localparam int CNT   = 2 * NCSA + NPASS;
    for (genvar g = 0; g < NCSA; g++) begin : g_csa
      assign tree_s[l][2*g]   = csa_sum(tree_s[l-1][3*g], tree_s[l-1][3*g+1], tree_s[l-1][3*g+2]);
      assign tree_s[l][2*g+1] = csa_carry(tree_s[l-1][3*g], tree_s[l-1][3*g+1], tree_s[l-1][3*g+2]);
    end
    for (genvar p = 0; p < NPASS; p++) begin : g_pass
      assign tree_s[l][2*NCSA+p] = tree_s[l-1][3*NCSA+p];
    end
    for (genvar z = CNT; z < NROWS; z++) begin : g_zero
      assign tree_s[l][z] = '0;
    end
  end

  assign prod_s = tree_s[NLVL][0] + tree_s[NLVL][1];

  // Output stage; result keeps the last product across idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
    end else begin
      out_valid_r <= v1_r;
      if (v1_r) begin
        result_r <= prod_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_vm_multiplier.sv
// Randomised bench for vm_multiplier: a cycle log of issued pairs yields the
// expected outputs every cycle, with literal pins for the hand-computed cases.
module tb_vm_multiplier;

  localparam int W    = 32;
  localparam int LOGN = 16384;
  localparam int NDIR = 14;

  localparam logic [31:0] TA [NDIR] = '{32'd50, 32'd90, -32'sd80, -32'sd10,
                                        32'd98756, 32'd98765, 32'd0,
                                        -32'sd500, -32'sd999, 32'd65535,
                                        32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
  localparam logic [31:0] TB [NDIR] = '{-32'sd40, 32'd70, -32'sd65, 32'd325,
                                        32'd0, 32'd1, 32'hFFFF_FFFF,
                                        32'd2000, 32'd999, 32'd65535,
                                        32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [63:0] TR [NDIR] = '{64'hFFFF_FFFF_FFFF_F830, 64'd6300, 64'd5200, -64'sd3250,
                                        64'd0, 64'd98765, 64'd0,
                                        64'hFFFF_FFFF_FFF0_BDC0, -64'sd998001, 64'd4294836225,
                                        64'h4000_0000_0000_0000, 64'h3FFF_FFFF_0000_0001,
                                        64'hC000_0000_8000_0000, 64'd1};

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [W-1:0]  a;
  logic signed [W-1:0]  b;
  logic                 out_valid;
  logic [2*W-1:0]       result;

  vm_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    bit          v;
    logic [63:0] r;
  } pin_t;

  int          n_cmp     = 0;
  int          n_bad     = 0;
  int          cyc       = 0;
  int          rst_floor = 0;
  bit          log_v [LOGN];
  logic [63:0] log_p [LOGN];
  pin_t        pin_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // log what each rising edge captures: the pair and its exact signed product
  initial begin
    forever begin
      @(posedge clk);
      if (cyc < LOGN) begin
        log_v[cyc] = in_valid && rst_n;
        log_p[cyc] = longint'(a) * longint'(b);
      end
      cyc = cyc + 1;
    end
  end

  // compare every cycle: output shows the pair captured two edges ago, result the latest valid one
  initial begin
    bit          exp_v;
    logic [63:0] exp_r;
    int          k;
    forever begin
      @(negedge clk);
      exp_v = 1'b0;
      exp_r = 64'd0;
      if (cyc >= 2 && cyc - 2 < LOGN) begin
        k = cyc - 2;
        if (k >= rst_floor) exp_v = log_v[k];
        for (int j = k; j >= rst_floor; j--) begin
          if (log_v[j]) begin
            exp_r = log_p[j];
            break;
          end
        end
      end
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
      check("result", result, exp_r);
      while (pin_q.size() > 0 && pin_q[0].due <= cyc) begin
        if (pin_q[0].due == cyc) begin
          check("pin_valid", {63'd0, out_valid}, {63'd0, pin_q[0].v});
          check("pin_result", result, pin_q[0].r);
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL pin_missed cyc=%0d got=unchecked want=due_%0d", cyc, pin_q[0].due);
        end
        void'(pin_q.pop_front());
      end
    end
  end

  task automatic issue(input bit v, input logic [31:0] x, input logic [31:0] y,
                       input bit pin, input logic [63:0] r);
    in_valid = v;
    a        = x;
    b        = y;
    if (pin) pin_q.push_back('{due: cyc + 2, v: v, r: r});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd0;
      4:       return 32'($urandom_range(0, 511)) - 32'd256;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed products, back-to-back
    for (int i = 0; i < NDIR; i++) issue(1'b1, TA[i], TB[i], 1'b1, TR[i]);
    issue(1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    issue(1'b0, 32'd0, 32'd0, 1'b0, 64'd0);

    // valid gating 1,0,1,1,0 -> out_valid 0,0,1,0,1,1,0 with result held in gaps
    pin_q.push_back('{due: cyc, v: 1'b0, r: 64'd1});
    pin_q.push_back('{due: cyc + 1, v: 1'b0, r: 64'd1});
    issue(1'b1, 32'd7, 32'd6, 1'b1, 64'd42);
    issue(1'b0, 32'd123, 32'd456, 1'b1, 64'd42);
    issue(1'b1, -32'sd3, 32'd5, 1'b1, -64'sd15);
    issue(1'b1, 32'd11, -32'sd11, 1'b1, -64'sd121);
    issue(1'b0, 32'd9, 32'd9, 1'b1, -64'sd121);
    issue(1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    issue(1'b0, 32'd0, 32'd0, 1'b0, 64'd0);

    // asynchronous reset with two products in flight
    issue(1'b1, 32'd1234, 32'd5678, 1'b0, 64'd0);
    issue(1'b1, -32'sd77, 32'd88, 1'b0, 64'd0);
    in_valid = 1'b1;
    a        = 32'sd3;
    b        = 32'sd4;
    #2;
    rst_floor = cyc;
    rst_n     = 1'b0;
    #1;
    check("async_reset_valid", {63'd0, out_valid}, 64'd0);
    check("async_reset_result", result, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    issue(1'b0, 32'd0, 32'd0, 1'b0, 64'd0);
    issue(1'b1, 32'd6, 32'd7, 1'b1, 64'd42);
    issue(1'b0, 32'd0, 32'd0, 1'b1, 64'd42);

    // random sweep
    for (int i = 0; i < 10000; i++) begin
      issue(($urandom_range(0, 7) != 0), rnd_op(), rnd_op(), 1'b0, 64'd0);
    end
    repeat (3) issue(1'b0, 32'd0, 32'd0, 1'b0, 64'd0);

    n_cmp++;
    if (pin_q.size() != 0) begin
      n_bad++;
      $display("FAIL pins_pending got=%0d want=0", pin_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
